// File: rtl/quad_step_decoder_pkg.sv
// Shared constants and Gray-sequence lookup for the quadrature step decoder.
// The same lookup is used by the decoder and by anything that needs to predict its direction.
package quad_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;

  // Forward (A leads) successor of a filtered {A,B} state.
  function automatic logic [1:0] quad_next_up(input logic [1:0] s);
    case (s)
      ST_00:   return ST_10;
      ST_10:   return ST_11;
      ST_11:   return ST_01;
      default: return ST_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_step_decoder_chan_filter.sv
// One encoder channel: synchroniser, debounce filter, and the stability run
// used once after reset to prime the decoder with the resting level.
module quad_chan_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enc_i,
  input  logic load_i,
  output logic filt_o,
  output logic stable_o,
  output logic value_o
);

  localparam logic [7:0] CNT_MAX  = 8'(FILTER_LEN - 1);
  localparam logic [7:0] STAB_MAX = 8'(FILTER_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic [7:0]             cnt_q;
  logic [7:0]             stab_q;
  logic                   filt_q;
  logic                   last_q;
  logic                   s;
  logic                   s_vld;

  assign s     = sync_q[SYNC_STAGES-1];
  assign s_vld = vld_q[SYNC_STAGES-1];

  // vld_q marks when s carries a real sample rather than the reset fill,
  // so the priming run never counts the cleared synchroniser as a level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      vld_q  <= '0;
      cnt_q  <= '0;
      stab_q <= '0;
      filt_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], enc_i};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};

      if (s_vld) begin
        last_q <= s;
        if (stab_q != 8'd0 && s != last_q) begin
          stab_q <= 8'd1;
        end else if (stab_q != STAB_MAX) begin
          stab_q <= stab_q + 8'd1;
        end
      end

      if (load_i) begin
        filt_q <= last_q;
        cnt_q  <= '0;
      end else if (s_vld && s != filt_q) begin
        if (cnt_q == CNT_MAX) begin
          filt_q <= s;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign filt_o   = filt_q;
  assign stable_o = (stab_q == STAB_MAX);
  assign value_o  = last_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end for counter_up_down: debounced Gray decode into
// a one-cycle step pulse, a held direction, and an illegal-transition flag.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int X1_MODE     = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic       counter_en,
  output logic       add_or_sub,
  output logic       step_err,
  output logic [1:0] ab_state
);

  logic       a_filt, b_filt;
  logic       a_stable, b_stable;
  logic       a_value, b_value;
  logic       load;
  logic [1:0] cur;
  logic [1:0] prev_q;
  logic       primed_q;
  logic       en_q, en_d;
  logic       err_q, err_d;
  logic       dir_q, dir_d;

  quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clock    (clock),
    .reset    (reset),
    .enc_i    (enc_a),
    .load_i   (load),
    .filt_o   (a_filt),
    .stable_o (a_stable),
    .value_o  (a_value)
  );

  quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clock    (clock),
    .reset    (reset),
    .enc_i    (enc_b),
    .load_i   (load),
    .filt_o   (b_filt),
    .stable_o (b_stable),
    .value_o  (b_value)
  );

  assign load = !primed_q && a_stable && b_stable;
  assign cur  = {a_filt, b_filt};

  always_comb begin
    en_d  = 1'b0;
    err_d = 1'b0;
    dir_d = dir_q;
    if (primed_q && cur != prev_q) begin
      if ((cur ^ prev_q) == 2'b11) begin
        err_d = 1'b1;
      end else if (X1_MODE == 0 || cur == ST_00) begin
        en_d  = 1'b1;
        dir_d = (quad_next_up(prev_q) == cur) ? DIR_UP : DIR_DOWN;
      end
    end
  end

  // The priming load seeds prev_q with the loaded state so it never decodes as a step.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q   <= ST_00;
      primed_q <= 1'b0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      dir_q    <= DIR_UP;
    end else begin
      prev_q   <= load ? {a_value, b_value} : cur;
      primed_q <= primed_q | load;
      en_q     <= en_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
    end
  end

  assign counter_en = en_q;
  assign step_err   = err_q;
  assign add_or_sub = dir_q;
  assign ab_state   = cur;

endmodule
